score_display: RTL and testbench

Consumer end of the score path: samples the 14-bit binary `score` bus from the score generator, converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low, 4-digit 7-segment display. It sits between the score generator and the board display pins. It also exposes the BCD value for other consumers.

---
 rtl/score_pkg.sv | 43 ++++
 rtl/bin2bcd_iter.sv | 98 +++++++++
 rtl/score_display.sv | 75 +++++++
 tb/tb_score_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared widths, limits, 7-segment patterns and converter state type for the score display path.
package score_pkg;

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4 * DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {StIdle, StConv} conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative shift-add-3 binary to BCD converter; one bit per cycle, input saturated at 9999.
module bin2bcd_iter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid
);

  localparam logic [3:0] LAST_ITER = 4'(SCORE_W - 1);

  conv_state_e        state_q, state_d;
  logic [SCORE_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0]   acc_q, acc_d, acc_adj;
  logic [3:0]         iter_q, iter_d;
  logic [SCORE_W-1:0] last_q, last_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] clamped;
  logic               changed;

  assign clamped = (bin > SCORE_MAX) ? SCORE_MAX : bin;
  assign changed = (clamped != last_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (changed) state_d = StConv;
      StConv: if (iter_q == LAST_ITER) state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (changed) begin
          shreg_d = clamped;
          acc_d   = '0;
          iter_d  = '0;
          // Recording the captured value now is equivalent to recording it at the end,
          // since the comparison only runs again once the conversion has finished.
          last_d  = clamped;
        end
      end
      StConv: begin
        {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
        if (iter_q == LAST_ITER) begin
          bcd_d   = acc_d;
          valid_d = 1'b1;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/score_display.sv
// Score display top: registers the score, converts it to BCD and scans a 4-digit
// active-low 7-segment display with optional leading-zero blanking.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [SCORE_W-1:0] score_q;
  logic [PW-1:0]      presc_q;
  logic [1:0]         idx_q;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q;
  logic [3:0]         nib;
  logic [BCD_W-1:0]   upper;
  logic               blank;

  bin2bcd_iter u_conv (
    .clk       (clk),
    .reset     (reset),
    .bin       (score_q),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  always_comb begin
    nib   = bcd[4*idx_q +: 4];
    // Current digit and everything above it
    upper = bcd >> {idx_q, 2'b00};
    blank = BLANK_LZ && (idx_q != 2'd0) && (upper == '0);
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : seg_decode(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_0;
      dp_q    <= 1'b1;
    end else begin
      score_q <= score;
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a fast scan rate and both blanking modes.
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] score;
  logic [15:0] bcd, bcd_nb;
  logic        bcd_valid, bcd_valid_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  score_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .bcd       (bcd_nb),
    .bcd_valid (bcd_valid_nb),
    .an        (an_nb),
    .seg       (seg_nb),
    .dp        (dp_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a bcd_valid pulse, then checks the converted value.
  task automatic wait_valid(input string tag, input logic [15:0] exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bcd_valid && n < 40);
    check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
  endtask

  // exp_b / exp_n: slot k pattern at [7*k +: 7] for the blanking / non-blanking instances.
  task automatic scan_check(input string tag, input logic [27:0] exp_b, input logic [27:0] exp_n);
    logic [3:0] prev;
    logic [3:0] exp_an;
    bit found = 1'b0;
    prev = an;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
      else prev = an;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        exp_an = ~(4'b0001 << k);
        for (int c = 0; c < 4; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          check($sformatf("%s_an_k%0d_c%0d", tag, k, c), 32'(an), 32'(exp_an));
          check($sformatf("%s_an_nb_k%0d_c%0d", tag, k, c), 32'(an_nb), 32'(exp_an));
          check($sformatf("%s_seg_k%0d_c%0d", tag, k, c), 32'(seg), 32'(exp_b[7*k +: 7]));
          check($sformatf("%s_seg_nb_k%0d_c%0d", tag, k, c), 32'(seg_nb),
                32'(exp_n[7*k +: 7]));
          check($sformatf("%s_dp_k%0d_c%0d", tag, k, c), 32'(dp), 32'd1);
        end
      end
    end
  endtask

  initial begin
    int pulses;
    logic [15:0] vals[$];
    logic [15:0] v0, v1;

    reset = 1'b1;
    score = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_an", 32'(an), 32'b1110);
    check("rst_seg", 32'(seg), 32'b1000000);
    check("rst_dp", 32'(dp), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Zero after reset: ones shows '0', upper digits blank (all '0' without blanking)
    scan_check("zero", {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    // Exact latency: bcd_valid only on the 16th edge after the change
    @(negedge clk);
    score = 14'd4321;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_valid_e%0d", i), 32'(bcd_valid), (i == 16) ? 32'd1 : 32'd0);
      if (i == 16) check("lat_bcd", 32'(bcd), 32'h4321);
    end

    @(negedge clk); score = 14'd9;
    wait_valid("v9", 16'h0009);
    @(negedge clk); score = 14'd10;
    wait_valid("v10", 16'h0010);
    @(negedge clk); score = 14'd999;
    wait_valid("v999", 16'h0999);
    @(negedge clk); score = 14'd1000;
    wait_valid("v1000", 16'h1000);

    // Saturation converts once; holding it must not retrigger
    @(negedge clk); score = 14'h3FFF;
    wait_valid("sat", 16'h9999);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bcd_valid) pulses++;
    end
    check("sat_hold_pulses", 32'(pulses), 32'd0);

    // 5 -> 6 -> 7 on consecutive cycles: 6 is skipped
    @(negedge clk); score = 14'd5;
    @(negedge clk); score = 14'd6;
    @(negedge clk); score = 14'd7;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bcd_valid) vals.push_back(bcd);
    end
    v0 = (vals.size() > 0) ? vals[0] : 16'hFFFF;
    v1 = (vals.size() > 1) ? vals[1] : 16'hFFFF;
    check("skip_pulses", 32'(vals.size()), 32'd2);
    check("skip_first", 32'(v0), 32'h0005);
    check("skip_second", 32'(v1), 32'h0007);

    // 42: '2','4', then blank/blank or '0'/'0'
    @(negedge clk); score = 14'd42;
    wait_valid("v42", 16'h0042);
    scan_check("s42", {7'h7F, 7'h7F, 7'b0011001, 7'b0100100},
               {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100});

    // Reset five cycles after capture aborts the conversion
    @(negedge clk); score = 14'd1234;
    pulses = 0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (bcd_valid) pulses++;
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    #1;
    if (bcd_valid) pulses++;
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_valid", 32'(bcd_valid), 32'd0);
    @(negedge clk); reset = 1'b0;
    check("abort_pulses", 32'(pulses), 32'd0);
    wait_valid("after_abort", 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
